// File: rtl/period_meter.sv
// period_meter: measures the spacing, in clock cycles, between consecutive
// rising edges of a slow asynchronous input.
//
// Ports:
//   clock    - system clock, all logic on its rising edge
//   reset_n  - asynchronous active-low reset
//   enable   - measurement enable; low forces IDLE and clears the counter
//   sig_in   - asynchronous measured signal
//   period   - last completed period in clock cycles (held between updates)
//   valid    - one-cycle pulse when period is updated
//   overflow - set when no edge arrives within the counter range, cleared by valid
//   locked   - high while a measurement is running
module period_meter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             locked
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             valid_nxt;
  logic             overflow_nxt;
  logic             s1, s2, s3;
  logic             rise;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // State, counter and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      period   <= period_nxt;
      valid    <= valid_nxt;
      overflow <= overflow_nxt;
      locked   <= (state_nxt == MEASURE);
    end
  end

  // Next-state and result logic; enable outranks rise, rise outranks saturation
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    period_nxt   = period;
    valid_nxt    = 1'b0;
    overflow_nxt = overflow;

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt   = cnt;
            valid_nxt    = 1'b1;
            overflow_nxt = 1'b0;
            cnt_nxt      = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            // No edge within range: abandon measurement, keep old period
            overflow_nxt = 1'b1;
            state_nxt    = IDLE;
            cnt_nxt      = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (WIDTH=16 and WIDTH=4) share the
// same stimulus and are checked every cycle against an edge-timestamp model.
module tb_period_meter;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        sig_in;
  logic [15:0] p16;
  logic        v16, o16, l16;
  logic [3:0]  p4;
  logic        v4, o4, l4;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  period_meter #(.WIDTH(16)) u_w16 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .period(p16), .valid(v16), .overflow(o16), .locked(l16)
  );

  period_meter #(.WIDTH(4)) u_w4 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .period(p4), .valid(v4), .overflow(o4), .locked(l4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: a measurement is the distance between timestamps of detected rises
  longint      maxv [2] = '{65535, 15};
  longint      last [2];
  bit          meas [2];
  longint      m_period [2];
  bit          m_valid [2];
  bit          m_ovf [2];
  bit          h1, h2, h3;
  longint      edge_n;
  bit          rise_m;

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      last[i] = 0; meas[i] = 0; m_period[i] = 0; m_valid[i] = 0; m_ovf[i] = 0;
    end
    h1 = 0; h2 = 0; h3 = 0; edge_n = 0;
  endtask

  // A sig_in sample taken at edge m is seen as a rise at edge m+2
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_clear();
    end else begin
      rise_m = h2 & ~h3;
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 0;
        if (!enable) begin
          meas[i] = 0;
        end else if (rise_m) begin
          if (meas[i]) begin
            m_period[i] = edge_n - last[i];
            m_valid[i]  = 1;
            m_ovf[i]    = 0;
          end
          meas[i] = 1;
          last[i] = edge_n;
        end else if (meas[i] && (edge_n - last[i] == maxv[i])) begin
          m_ovf[i] = 1;
          meas[i]  = 0;
        end
      end
      h3 = h2; h2 = h1; h1 = sig_in;
      edge_n++;
    end
    if (clock) begin
      #2;
      check("period16",   longint'(p16), m_period[0]);
      check("valid16",    longint'(v16), longint'(m_valid[0]));
      check("overflow16", longint'(o16), longint'(m_ovf[0]));
      check("locked16",   longint'(l16), longint'(meas[0]));
      check("period4",    longint'(p4),  m_period[1]);
      check("valid4",     longint'(v4),  longint'(m_valid[1]));
      check("overflow4",  longint'(o4),  longint'(m_ovf[1]));
      check("locked4",    longint'(l4),  longint'(meas[1]));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // n toggles of sig_in, each level held for 'half' cycles
  task automatic square(input int half, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = ~sig_in;
      wait_cycles(half);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    wait_cycles(3);
    check("rst_period16", longint'(p16), 0);
    check("rst_locked16", longint'(l16), 0);
    reset_n = 1'b1;
    wait_cycles(2);
    enable = 1'b1;

    // Basic period-16 measurement
    square(8, 12);
    check("basic_period16", longint'(p16), 16);
    check("basic_locked16", longint'(l16), 1);
    check("basic_ovf16",    longint'(o16), 0);

    // Period change to 10
    square(5, 10);
    check("change_period16", longint'(p16), 10);

    // Long low gap then held high: WIDTH=4 overflows, keeps last period
    wait_cycles(10);
    sig_in = 1'b1;
    wait_cycles(30);
    check("ovf_flag4",   longint'(o4), 1);
    check("ovf_locked4", longint'(l4), 0);
    check("ovf_period4", longint'(p4), 10);
    sig_in = 1'b0;
    wait_cycles(3);
    square(3, 8);
    check("restart_period4", longint'(p4), 6);
    check("restart_ovf4",    longint'(o4), 0);

    // Enable dropped for 20 cycles inside a period-16 stream
    fork
      square(8, 16);
      begin
        wait_cycles(40);
        enable = 1'b0;
        wait_cycles(20);
        enable = 1'b1;
      end
    join
    check("gate_period16", longint'(p16), 16);

    // Asynchronous reset between edges
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_period16",   longint'(p16), 0);
    check("arst_valid16",    longint'(v16), 0);
    check("arst_overflow16", longint'(o16), 0);
    check("arst_locked16",   longint'(l16), 0);
    check("arst_overflow4",  longint'(o4),  0);
    wait_cycles(3);
    reset_n = 1'b1;
    square(8, 8);
    check("post_rst_period16", longint'(p16), 16);

    // Minimum period of 2
    square(1, 40);
    check("min_period16", longint'(p16), 2);

    // Rises spaced exactly 15 apart: saturating count still reports
    for (int k = 0; k < 4; k++) begin
      sig_in = 1'b1;
      wait_cycles(7);
      sig_in = 1'b0;
      wait_cycles(8);
    end
    check("bound_period4", longint'(p4), 15);
    check("bound_ovf4",    longint'(o4), 0);

    // Randomised levels, hold times and enable drops
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 11) == 0) enable = ~enable;
      sig_in = ~sig_in;
      if ($urandom_range(0, 5) == 0) wait_cycles(int'($urandom_range(10, 20)));
      else wait_cycles(int'($urandom_range(1, 9)));
    end
    enable = 1'b1;
    wait_cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
